// File: rtl/breakout_pkg.sv
// Shared definitions for the breakout renderer.
//   draw_state_e   : brick sequencer states
//   BRICK_W/H      : brick size in pixels, sets the pixel counter widths
//   BRICK_*_MSB/LSB: field positions inside a brick memory record
package breakout_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StDraw  = 2'd2,
        StDone  = 2'd3
    } draw_state_e;

    localparam int unsigned BRICK_W = 16;
    localparam int unsigned BRICK_H = 4;

    localparam int unsigned CNT_X_W = $clog2(BRICK_W);
    localparam int unsigned CNT_Y_W = $clog2(BRICK_H);

    // Brick record layout: x [18:11], y [9:3], colour [2:0]
    localparam int unsigned BRICK_X_MSB      = 18;
    localparam int unsigned BRICK_X_LSB      = 11;
    localparam int unsigned BRICK_Y_MSB      = 9;
    localparam int unsigned BRICK_Y_LSB      = 3;
    localparam int unsigned BRICK_COLOUR_MSB = 2;
    localparam int unsigned BRICK_COLOUR_LSB = 0;

endpackage

// File: rtl/brick_pixel_counter.sv
// Pixel offset counter for one brick (x runs fastest, y steps when x wraps).
//   clock, reset_regs : clock and asynchronous active-low reset
//   en                : advance one pixel
//   clr               : return to (0,0); takes priority over en
//   cnt_x, cnt_y      : current pixel offset
//   last              : current pixel is the bottom-right corner
module brick_pixel_counter
    import breakout_pkg::*;
(
    input  logic               clock,
    input  logic               reset_regs,
    input  logic               en,
    input  logic               clr,
    output logic [CNT_X_W-1:0] cnt_x,
    output logic [CNT_Y_W-1:0] cnt_y,
    output logic               last
);

    localparam logic [CNT_X_W-1:0] XMax = CNT_X_W'(BRICK_W - 1);
    localparam logic [CNT_Y_W-1:0] YMax = CNT_Y_W'(BRICK_H - 1);

    logic [CNT_X_W-1:0] x_q, x_d;
    logic [CNT_Y_W-1:0] y_q, y_d;

    always_ff @(posedge clock or negedge reset_regs) begin
        if (!reset_regs) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    // Both counters wrap naturally, so advancing past the last pixel lands on (0,0).
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr) begin
            x_d = '0;
            y_d = '0;
        end else if (en) begin
            x_d = x_q + CNT_X_W'(1);
            if (x_q == XMax) begin
                y_d = y_q + CNT_Y_W'(1);
            end
        end
    end

    assign cnt_x = x_q;
    assign cnt_y = y_q;
    assign last  = (x_q == XMax) && (y_q == YMax);

endmodule

// File: rtl/brick_draw_ctrl.sv
// Brick renderer sequencer: fetches each brick record, loads the display
// registers, then sweeps every pixel of the brick with plot asserted.
//   clock, reset_regs    : clock and asynchronous active-low reset
//   start                : redraw request, only honoured when idle
//   hold                 : arbiter freeze; position is kept, strobes drop
//   mem_ready            : brick memory data valid
//   mem_rd, mem_addr     : brick memory read request and record address
//   load_regs            : load brick x/y/colour into the display registers
//   brick_counter_x/y    : pixel offset inside the current brick
//   plot                 : VGA write enable
//   busy, done           : activity flag and end-of-frame pulse
module brick_draw_ctrl
    import breakout_pkg::*;
#(
    parameter int unsigned NUM_BRICKS = 40,
    parameter int unsigned ADDR_W     = 6
) (
    input  logic               clock,
    input  logic               reset_regs,
    input  logic               start,
    input  logic               hold,
    input  logic               mem_ready,
    output logic               mem_rd,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               load_regs,
    output logic [CNT_X_W-1:0] brick_counter_x,
    output logic [CNT_Y_W-1:0] brick_counter_y,
    output logic               plot,
    output logic               busy,
    output logic               done
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_BRICKS - 1);

    draw_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              plot_q, plot_d;
    logic              cnt_en, cnt_clr, pix_last;

    brick_pixel_counter u_pixel_counter (
        .clock      (clock),
        .reset_regs (reset_regs),
        .en         (cnt_en),
        .clr        (cnt_clr),
        .cnt_x      (brick_counter_x),
        .cnt_y      (brick_counter_y),
        .last       (pix_last)
    );

    // State register, address and registered plot enable.
    always_ff @(posedge clock or negedge reset_regs) begin
        if (!reset_regs) begin
            state_q <= StIdle;
            addr_q  <= '0;
            plot_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            plot_q  <= plot_d;
        end
    end

    // Next-state logic. Hold freezes FETCH/DRAW; IDLE and DONE ignore it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StFetch;
            StFetch: if (!hold && mem_ready) state_d = StDraw;
            StDraw: begin
                if (!hold && pix_last) begin
                    state_d = (addr_q == LastAddr) ? StDone : StFetch;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Address and pixel counter control. The counter wraps to (0,0) on its
    // own after the last pixel, so moving to the next brick needs no clear.
    always_comb begin
        addr_d  = addr_q;
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d  = '0;
                    cnt_clr = 1'b1;
                end
            end
            StFetch: ;
            StDraw: begin
                cnt_en = !hold;
                if (!hold && pix_last && (addr_q != LastAddr)) begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            StDone: begin
                addr_d  = '0;
                cnt_clr = 1'b1;
            end
            default: ;
        endcase
        plot_d = (state_d == StDraw);
    end

    // Outputs. Hold must suppress the strobes in the cycle it is raised,
    // hence the combinational gating on top of the registered plot.
    always_comb begin
        mem_rd    = (state_q == StFetch) && !hold;
        load_regs = (state_q == StFetch) && !hold && mem_ready;
        plot      = plot_q && !hold;
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        mem_addr  = addr_q;
    end

endmodule

// File: tb/tb_brick_draw_ctrl.sv
// Bench for brick_draw_ctrl: a 40-brick instance exercising full, slow-memory,
// hold, busy-start, hold-in-idle and mid-frame reset scenarios, plus a
// single-brick instance for the one-record boundary.
module tb_brick_draw_ctrl;

    logic clock = 1'b0;
    logic reset_regs = 1'b0;
    always #5 clock = ~clock;

    // 40-brick instance
    logic       start = 1'b0, hold = 1'b0, mem_ready = 1'b0;
    logic       mem_rd, load_regs, plot, busy, done;
    logic [5:0] mem_addr;
    logic [3:0] bx;
    logic [1:0] by;

    // single-brick instance
    logic       b_start = 1'b0, b_hold = 1'b0, b_mem_ready = 1'b1;
    logic       b_mem_rd, b_load_regs, b_plot, b_busy, b_done;
    logic [5:0] b_mem_addr;
    logic [3:0] b_bx;
    logic [1:0] b_by;

    brick_draw_ctrl #(.NUM_BRICKS(40), .ADDR_W(6)) dut (
        .clock           (clock),
        .reset_regs      (reset_regs),
        .start           (start),
        .hold            (hold),
        .mem_ready       (mem_ready),
        .mem_rd          (mem_rd),
        .mem_addr        (mem_addr),
        .load_regs       (load_regs),
        .brick_counter_x (bx),
        .brick_counter_y (by),
        .plot            (plot),
        .busy            (busy),
        .done            (done)
    );

    brick_draw_ctrl #(.NUM_BRICKS(1), .ADDR_W(6)) dut_one (
        .clock           (clock),
        .reset_regs      (reset_regs),
        .start           (b_start),
        .hold            (b_hold),
        .mem_ready       (b_mem_ready),
        .mem_rd          (b_mem_rd),
        .mem_addr        (b_mem_addr),
        .load_regs       (b_load_regs),
        .brick_counter_x (b_bx),
        .brick_counter_y (b_by),
        .plot            (b_plot),
        .busy            (b_busy),
        .done            (b_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: brick addresses expected on each load_regs strobe.
    logic [5:0] exp_addr_q[$];

    int cyc = 0, start_cyc = 0;
    int pix = 0, nplot = 0, nload = 0, nrd = 0, ndone = 0, done_len = 0;
    int b_start_cyc = 0, b_nplot = 0, b_nload = 0, b_nrd = 0, b_ndone = 0, b_done_len = 0;

    always @(negedge clock) begin
        if (reset_regs) begin
            cyc++;
            if (load_regs) begin
                nload++;
                pix = 0;
                if (exp_addr_q.size() == 0) check("load_extra", 1, 0);
                else check("load_addr", mem_addr, exp_addr_q.pop_front());
            end
            if (plot) begin
                check("pix_seq", {by, bx}, pix[5:0]);
                pix++;
                nplot++;
            end
            if (mem_rd) nrd++;
            if (done) begin
                ndone++;
                done_len = cyc - start_cyc;
            end
            if (b_load_regs) b_nload++;
            if (b_plot) b_nplot++;
            if (b_mem_rd) b_nrd++;
            if (b_done) begin
                b_ndone++;
                b_done_len = cyc - b_start_cyc;
                check("one_done_addr", b_mem_addr, 0);
            end
        end
    end

    // Memory model: data valid immediately, or on the 4th read cycle when slow.
    bit slow_mode = 0;
    int wait_cnt = 0;
    initial forever begin
        @(posedge clock);
        #2;
        if (mem_rd) wait_cnt++;
        else wait_cnt = 0;
        mem_ready = slow_mode ? (wait_cnt >= 4) : 1'b1;
    end

    // Called at posedge+1; start is sampled by the following edge.
    task automatic begin_frame();
        pix = 0; nplot = 0; nload = 0; nrd = 0; ndone = 0; done_len = 0;
        for (int i = 0; i < 40; i++) exp_addr_q.push_back(6'(i));
        start = 1'b1;
        @(posedge clock);
        start_cyc = cyc;
        #1 start = 1'b0;
    endtask

    task automatic end_frame(input string tag, input int exp_len, input int exp_rd);
        for (int i = 0; i < 3200 && ndone == 0; i++) @(posedge clock);
        #1;
        check({tag, "_done_seen"}, ndone, 1);
        check({tag, "_done_len"}, done_len, exp_len);
        check({tag, "_plots"}, nplot, 2560);
        check({tag, "_loads"}, nload, 40);
        check({tag, "_reads"}, nrd, exp_rd);
        check({tag, "_sb_left"}, exp_addr_q.size(), 0);
        repeat (3) @(posedge clock);
        #1;
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_addr"}, mem_addr, 0);
        check({tag, "_single_done"}, ndone, 1);
    endtask

    task automatic wait_pixel(input int a, input int x, input int y, input string tag);
        bit found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(posedge clock);
            #1;
            if (plot && mem_addr == a && bx == x && by == y) found = 1;
        end
        check(tag, found, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd"}, mem_rd, 0);
        check({tag, "_load"}, load_regs, 0);
        check({tag, "_plot"}, plot, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_pix"}, {by, bx}, 0);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        check("reset_one_busy", b_busy, 0);
        reset_regs = 1'b1;
        @(posedge clock);
        #1;

        // Full frame, memory always ready.
        begin_frame();
        end_frame("full", 2601, 40);

        // Slow memory: 3 wait cycles per fetch.
        slow_mode = 1;
        begin_frame();
        end_frame("slow", 2721, 160);
        slow_mode = 0;
        @(posedge clock);
        #1;

        // Hold at (9,1) of brick 2 for 10 cycles, then start while busy at brick 20.
        begin_frame();
        wait_pixel(2, 9, 1, "hold_reach");
        hold = 1'b1;
        repeat (10) begin
            @(negedge clock);
            check("hold_plot", plot, 0);
            check("hold_pix", {by, bx}, {2'd1, 4'd9});
            check("hold_addr", mem_addr, 2);
            @(posedge clock);
            #1;
        end
        hold = 1'b0;
        wait_pixel(20, 0, 0, "busy_reach");
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        check("busy_start_addr", mem_addr, 20);
        check("busy_start_busy", busy, 1);
        end_frame("hold", 2611, 40);

        // Start accepted under hold; FETCH stays frozen with mem_ready high.
        hold = 1'b1;
        begin_frame();
        repeat (3) begin
            @(negedge clock);
            check("idle_hold_busy", busy, 1);
            check("idle_hold_rd", mem_rd, 0);
            check("idle_hold_load", load_regs, 0);
            @(posedge clock);
            #1;
        end
        hold = 1'b0;
        end_frame("idle_hold", 2604, 40);

        // Reset at (7,2) of brick 5, then a clean redraw.
        begin_frame();
        wait_pixel(5, 7, 2, "rst_reach");
        reset_regs = 1'b0;
        @(negedge clock);
        check_all_zero("rst_mid");
        @(posedge clock);
        #1 reset_regs = 1'b1;
        exp_addr_q.delete();
        begin_frame();
        end_frame("after_rst", 2601, 40);

        // Single-brick instance.
        b_start = 1'b1;
        @(posedge clock);
        b_start_cyc = cyc;
        #1 b_start = 1'b0;
        for (int i = 0; i < 200 && b_ndone == 0; i++) @(posedge clock);
        #1;
        check("one_done_len", b_done_len, 66);
        repeat (50) @(posedge clock);
        #1;
        check("one_ndone", b_ndone, 1);
        check("one_plots", b_nplot, 64);
        check("one_loads", b_nload, 1);
        check("one_reads", b_nrd, 1);
        check("one_busy", b_busy, 0);
        check("one_addr", b_mem_addr, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
